count_seq_checker: RTL
======================

# count_seq_checker

Receive-side checker for the ripple-carry counter's output bus. It samples a WIDTH-bit count value on qualified cycles and locks onto an incrementing modulo-2^WIDTH sequence. Once locked, it flags every sample that breaks the sequence and keeps saturating error and wrap statistics. It sits next to the counter in block and system benches, and can be instantiated as an on-chip health monitor.

## Interface
- WIDTH, 4, width of the monitored count bus
- LOCK_CNT, 3, consecutive correct increments required to lock (≥1)
- UNLOCK_ERRS, 2, consecutive mismatches while locked that force re-acquisition (≥1)
- STAT_W, 8, width of the error and wrap statistics counters
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- q_in  input  WIDTH  observed counter value
- q_valid  input  1  q_in is sampled on this cycle only when high
- locked  output  1  checker is locked to the sequence
- error  output  1  one-cycle pulse per mismatching sample while locked
- err_count  output  STAT_W  saturating count of error pulses
- wrap_count  output  STAT_W  saturating count of locked all-ones→zero transitions

## Operation
- Internal registers:
  - prev (WIDTH): last sampled value.
  - good_cnt: ACQUIRE progress.
  - miss_cnt: consecutive mismatches while locked.
  - state: IDLE, ACQUIRE or LOCKED.
- expected = prev + 1, truncated to WIDTH bits. All-ones wraps to 0.
- IDLE (reset state): on q_valid, prev ← q_in, good_cnt ← 0, go to ACQUIRE. No error, no stats.
- ACQUIRE, on q_valid:
  - q_in == expected: good_cnt ← good_cnt+1. If good_cnt+1 == LOCK_CNT, go to LOCKED and set miss_cnt ← 0.
  - Otherwise: good_cnt ← 0, stay in ACQUIRE. The mismatch does not raise error and does not count.
  - In both cases prev ← q_in.
- LOCKED, on q_valid:
  - Match: miss_cnt ← 0. If prev is all-ones and q_in == 0, wrap_count increments (saturating).
  - Mismatch: error pulses, err_count increments (saturating), miss_cnt ← miss_cnt+1. If miss_cnt+1 == UNLOCK_ERRS, go to ACQUIRE with good_cnt ← 0. That final mismatch still pulses error.
  - In both cases prev ← q_in: the checker resyncs to the observed value.
- q_valid low: no register changes. error is low.
- locked is high exactly when state == LOCKED.
- Statistics:
  - Saturate at 2^STAT_W−1 and never wrap.
  - Are cleared only by rst. They persist across unlock and relock.
- A repeated value (q_in == prev) is a mismatch.
- WIDTH=1 is legal: the sequence alternates 0,1,0,1…

## Timing
- All outputs are registered. Every response appears on the cycle after the clock edge that samples q_valid.
- Reset values (rst high at a clock edge, takes priority over every other input):
  - state = IDLE, prev = 0, good_cnt = 0, miss_cnt = 0.
  - locked = 0, error = 0, err_count = 0, wrap_count = 0.
- rst asserted mid-sequence or while locked returns to IDLE on that edge and discards all history. The sample present on that cycle is ignored.
- Lock latency after the first (IDLE) sample: LOCK_CNT further matching valid samples. locked rises the cycle after the LOCK_CNT-th match edge.
- Unlock: locked falls the same cycle that the UNLOCK_ERRS-th error pulse is high.
- Back-to-back valid samples are supported at full rate. Gaps in q_valid do not break the sequence.
- Boundary behaviour:
  - Simultaneous error and wrap is impossible: a wrap is by definition a match.
  - A mismatch whose q_in is 0 after an all-ones prev counts as a wrap only if it matches, and it always matches. No special case is needed.

## Test plan
1. rst=1 for 2 cycles, then q_valid=1 with q_in = 0,1,2,3,4… each cycle (LOCK_CNT=3).
   - locked=0 through sample 2; locked=1 the cycle after sample 3.
   - error never high; err_count=0.
2. Locked free-run for 40 samples from 0.
   - wrap_count=2 after the second 15→0 transition.
   - err_count=0.
3. Locked stream 5,6,7,9,10.
   - One error pulse the cycle after sample 9; err_count=1; locked stays 1.
   - Sample 10 matches, and miss_cnt clears.
4. Locked stream 5,6,6,2 (UNLOCK_ERRS=2).
   - Error pulses after the second 6 and after 2; err_count=2.
   - locked falls with the second pulse.
   - Relock after 3,4,5.
5. Valid stream 0,1 then q_valid=0 for 5 cycles, then 2,3.
   - Gaps are ignored; locked=1 after sample 3.
6. Locked with err_count=7, assert rst for 1 cycle mid-stream.
   - Next cycle: locked=0, err_count=0, wrap_count=0, state IDLE.
   - Saturation check with STAT_W=2: 5 errors leave err_count=3.

Source files
------------

// File: rtl/count_seq_if.sv
// count_seq_if: bus between a counter (or bench) and count_seq_checker.
//   master: drives q_in/q_valid, observes the checker status.
//   slave : samples q_in/q_valid, drives locked/error/err_count/wrap_count.
interface count_seq_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAT_W = 8
);
    logic [WIDTH-1:0]  q_in;        // observed counter value
    logic              q_valid;     // q_in qualifier
    logic              locked;      // checker locked to the sequence
    logic              error;       // one-cycle mismatch pulse while locked
    logic [STAT_W-1:0] err_count;   // saturating error pulse count
    logic [STAT_W-1:0] wrap_count;  // saturating locked wrap count

    modport master (
        output q_in, q_valid,
        input  locked, error, err_count, wrap_count
    );

    modport slave (
        input  q_in, q_valid,
        output locked, error, err_count, wrap_count
    );
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto an incrementing modulo-2^WIDTH sequence seen on
// bus.q_in (sampled when bus.q_valid is high), then flags every sample that breaks
// it and keeps saturating error and wrap statistics.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - count_seq_if slave: q_in/q_valid in; locked/error/err_count/wrap_count out
// All outputs are registered.
module count_seq_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned LOCK_CNT    = 3,
    parameter int unsigned UNLOCK_ERRS = 2,
    parameter int unsigned STAT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    count_seq_if.slave  bus
);
    // Counters only need to reach their terminal value.
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [GW-1:0]     good_q, good_d;
    logic [MW-1:0]     miss_q, miss_d;
    logic              error_q, error_d;
    logic [STAT_W-1:0] err_q, err_d;
    logic [STAT_W-1:0] wrap_q, wrap_d;

    logic [WIDTH-1:0]  expected;
    logic              match;
    logic [GW-1:0]     good_inc;
    logic [MW-1:0]     miss_inc;

    assign expected = prev_q + 1'b1;
    assign match    = (bus.q_in == expected);
    assign good_inc = good_q + 1'b1;
    assign miss_inc = miss_q + 1'b1;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        miss_d  = miss_q;
        error_d = 1'b0;
        err_d   = err_q;
        wrap_d  = wrap_q;

        if (bus.q_valid) begin
            // The checker always resyncs to the observed value.
            prev_d = bus.q_in;
            unique case (state_q)
                StIdle: begin
                    good_d  = '0;
                    state_d = StAcquire;
                end
                StAcquire: begin
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_d = StLocked;
                            miss_d  = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                StLocked: begin
                    if (match) begin
                        miss_d = '0;
                        // A match from all-ones can only land on zero.
                        if (prev_q == '1 && wrap_q != '1) begin
                            wrap_d = wrap_q + 1'b1;
                        end
                    end else begin
                        error_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        miss_d = miss_inc;
                        if (miss_inc == MW'(UNLOCK_ERRS)) begin
                            state_d = StAcquire;
                            good_d  = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            prev_q  <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            error_q <= 1'b0;
            err_q   <= '0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            error_q <= error_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.locked     = (state_q == StLocked);
    assign bus.error      = error_q;
    assign bus.err_count  = err_q;
    assign bus.wrap_count = wrap_q;
endmodule
